// File: rtl/bank_timing_tracker_pkg.sv
// Shared types, register map and reset timing values for the bank timing tracker.
// Timed states use timed_load() so that a duration of T cycles loads T-1 (T=0 acts as 1).
package bank_timing_pkg;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ACTIVATING, ST_ACTIVE, ST_READING,
      ST_WRITING, ST_PRECHARGING, ST_REFRESHING
   } bank_state_e;

   typedef enum logic [2:0] {
      OP_ACT, OP_RD, OP_RDA, OP_WR, OP_WRA, OP_PRE, OP_PREA, OP_REF
   } cmd_op_e;

   typedef enum logic [2:0] {
      VC_NONE, VC_STATE, VC_PRE_TIMING, VC_RRD, VC_FAW, VC_CCD, VC_REF
   } viol_code_e;

   localparam int unsigned REG_CL    = 0;
   localparam int unsigned REG_RCD   = 1;
   localparam int unsigned REG_RP    = 2;
   localparam int unsigned REG_RFC   = 3;
   localparam int unsigned REG_WR    = 4;
   localparam int unsigned REG_RTP   = 5;
   localparam int unsigned REG_CWL   = 6;
   localparam int unsigned REG_RAS   = 7;
   localparam int unsigned REG_RRD_S = 8;
   localparam int unsigned REG_RRD_L = 9;
   localparam int unsigned REG_FAW   = 10;
   localparam int unsigned REG_CCD_S = 11;
   localparam int unsigned REG_CCD_L = 12;
   localparam int unsigned REG_REFI  = 13;
   localparam int unsigned NREG8     = 13;

   localparam logic [15:0] DEF_REFI = 16'd9360;

   function automatic logic [7:0] default_timing(input int unsigned idx);
      logic [7:0] r;
      case (idx)
         REG_CL:    r = 8'd17;
         REG_RCD:   r = 8'd17;
         REG_RP:    r = 8'd17;
         REG_RFC:   r = 8'd34;
         REG_WR:    r = 8'd14;
         REG_RTP:   r = 8'd7;
         REG_CWL:   r = 8'd10;
         REG_RAS:   r = 8'd32;
         REG_RRD_S: r = 8'd4;
         REG_RRD_L: r = 8'd6;
         REG_FAW:   r = 8'd16;
         REG_CCD_S: r = 8'd4;
         REG_CCD_L: r = 8'd6;
         default:   r = 8'd0;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] timed_load(input logic [15:0] t);
      return (t == 16'd0) ? 16'd0 : t - 16'd1;
   endfunction

endpackage

// File: rtl/bank_timing_tracker_if.sv
// Command, configuration and status bundle between command decode and the tracker.
interface bank_timing_tracker_if #(
   parameter int BGWIDTH = 2,
   parameter int BAWIDTH = 2
);
   import bank_timing_pkg::*;

   localparam int BANKGROUPS    = 2 ** BGWIDTH;
   localparam int BANKSPERGROUP = 2 ** BAWIDTH;

   logic                 cmd_valid;
   cmd_op_e              cmd_op;
   logic [BGWIDTH-1:0]   bg;
   logic [BAWIDTH-1:0]   ba;
   logic                 cfg_we;
   logic [3:0]           cfg_addr;
   logic [15:0]          cfg_wdata;
   logic                 cmd_ok;
   logic                 viol;
   logic [2:0]           viol_code;
   logic                 ref_due;
   logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][2:0] bank_state;

   modport master (
      output cmd_valid, cmd_op, bg, ba, cfg_we, cfg_addr, cfg_wdata,
      input  cmd_ok, viol, viol_code, ref_due, bank_state
   );

   modport slave (
      input  cmd_valid, cmd_op, bg, ba, cfg_we, cfg_addr, cfg_wdata,
      output cmd_ok, viol, viol_code, ref_due, bank_state
   );
endinterface

// File: rtl/bank_timing_tracker_bank_timer.sv
// Per-bank state machine with its state duration counter and the tRAS/tWR/tRTP
// counters that gate precharge. Only commands already judged legal reach it.
module bank_timer
   import bank_timing_pkg::*;
#(
   parameter int CTW = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_go,
   input  cmd_op_e     cmd_op,
   input  logic        hit,
   input  logic [15:0] t_rcd,
   input  logic [15:0] t_rd,
   input  logic [15:0] t_wr,
   input  logic [15:0] t_wra,
   input  logic [15:0] t_rp,
   input  logic [15:0] t_rfc,
   input  logic [15:0] t_ras,
   input  logic [15:0] t_rtp,
   output bank_state_e state,
   output logic        pre_ok
);
   localparam logic [15:0] CNT_MAX = 16'((1 << CTW) - 1);

   bank_state_e    state_reg, state_next;
   logic [CTW-1:0] cnt_reg, cnt_next;
   logic [CTW-1:0] ras_reg, ras_next;
   logic [CTW-1:0] wr_reg, wr_next;
   logic [CTW-1:0] rtp_reg, rtp_next;
   logic           auto_reg, auto_next;

   // Long sums (e.g. tCWL+BL/2+tWR) saturate rather than wrap in a narrow counter.
   function automatic logic [CTW-1:0] ld(input logic [15:0] t);
      logic [15:0] v;
      v = timed_load(t);
      return (v > CNT_MAX) ? CNT_MAX[CTW-1:0] : v[CTW-1:0];
   endfunction

   function automatic logic [CTW-1:0] dec(input logic [CTW-1:0] c);
      return (c != '0) ? c - 1'b1 : c;
   endfunction

   assign state  = state_reg;
   assign pre_ok = (ras_reg == '0) && (wr_reg == '0) && (rtp_reg == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         ras_reg   <= '0;
         wr_reg    <= '0;
         rtp_reg   <= '0;
         auto_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ras_reg   <= ras_next;
         wr_reg    <= wr_next;
         rtp_reg   <= rtp_next;
         auto_reg  <= auto_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = dec(cnt_reg);
      ras_next   = dec(ras_reg);
      wr_next    = dec(wr_reg);
      rtp_next   = dec(rtp_reg);
      auto_next  = auto_reg;

      case (state_reg)
         ST_ACTIVATING:
            if (cnt_reg == '0) state_next = ST_ACTIVE;
         ST_READING, ST_WRITING:
            if (cnt_reg == '0) begin
               if (auto_reg) begin
                  state_next = ST_PRECHARGING;
                  cnt_next   = ld(t_rp);
               end else begin
                  state_next = ST_ACTIVE;
               end
            end
         ST_PRECHARGING, ST_REFRESHING:
            if (cnt_reg == '0) state_next = ST_IDLE;
         default: ;
      endcase

      if (cmd_go) begin
         case (cmd_op)
            OP_ACT: if (hit) begin
               state_next = ST_ACTIVATING;
               cnt_next   = ld(t_rcd);
               ras_next   = ld(t_ras);
            end
            OP_RD, OP_RDA: if (hit) begin
               state_next = ST_READING;
               cnt_next   = ld(t_rd);
               rtp_next   = ld(t_rtp);
               auto_next  = (cmd_op == OP_RDA);
            end
            OP_WR, OP_WRA: if (hit) begin
               state_next = ST_WRITING;
               cnt_next   = (cmd_op == OP_WRA) ? ld(t_wra) : ld(t_wr);
               wr_next    = ld(t_wra);
               auto_next  = (cmd_op == OP_WRA);
            end
            OP_PRE: if (hit) begin
               state_next = ST_PRECHARGING;
               cnt_next   = ld(t_rp);
            end
            // Active banks still inside their precharge window are simply skipped.
            OP_PREA: if (state_reg == ST_ACTIVE && pre_ok) begin
               state_next = ST_PRECHARGING;
               cnt_next   = ld(t_rp);
            end
            OP_REF: begin
               state_next = ST_REFRESHING;
               cnt_next   = ld(t_rfc);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/bank_timing_tracker.sv
// Rank-level command legality checker: timing registers, tRRD/tFAW/tCCD history,
// refresh interval tracking and one bank_timer per bank.
module bank_timing_tracker
   import bank_timing_pkg::*;
#(
   parameter int BL      = 8,
   parameter int BGWIDTH = 2,
   parameter int BAWIDTH = 2,
   parameter int CTW     = 8
) (
   input logic clk,
   input logic rst,
   bank_timing_tracker_if.slave bus
);
   localparam int BANKGROUPS    = 2 ** BGWIDTH;
   localparam int BANKSPERGROUP = 2 ** BAWIDTH;
   localparam int NBANKS        = BANKGROUPS * BANKSPERGROUP;
   localparam int SELW          = BGWIDTH + BAWIDTH;

   logic [7:0]  tim_reg [NREG8];
   logic [15:0] refi_reg, refi_cnt_reg, stamp_reg;
   logic        ref_due_reg, viol_reg;
   logic [2:0]  viol_code_reg;

   logic [15:0]           act_last_reg, col_last_reg;
   logic                  act_last_vld_reg, col_last_vld_reg;
   logic [15:0]           act_bg_reg [BANKGROUPS];
   logic [15:0]           col_bg_reg [BANKGROUPS];
   logic [BANKGROUPS-1:0] act_bg_vld_reg, col_bg_vld_reg;
   logic [15:0]           faw_reg [4];
   logic [3:0]            faw_vld_reg;
   logic [1:0]            faw_ptr_reg;

   bank_state_e       st_flat [NBANKS];
   logic [NBANKS-1:0] pre_ok_flat;
   logic [SELW-1:0]   sel;
   viol_code_e        code;
   logic              accept, is_col, all_idle, prea_bad, rrd_bad, faw_bad, ccd_bad;
   logic [15:0]       bl2, t_rd, t_wr, t_wra;
   logic [15:0]       d_act, d_act_bg, d_col, d_col_bg, d_faw;

   assign sel   = {bus.bg, bus.ba};
   assign bl2   = 16'(BL / 2);
   assign t_rd  = {8'd0, tim_reg[REG_CL]} + bl2;
   assign t_wr  = {8'd0, tim_reg[REG_CWL]} + bl2;
   assign t_wra = t_wr + {8'd0, tim_reg[REG_WR]};

   genvar gi;
   generate
      for (gi = 0; gi < NBANKS; gi++) begin : g_bank
         localparam int G = gi / BANKSPERGROUP;
         localparam int A = gi % BANKSPERGROUP;
         bank_timer #(.CTW(CTW)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .cmd_go (accept),
            .cmd_op (bus.cmd_op),
            .hit    (sel == SELW'(gi)),
            .t_rcd  ({8'd0, tim_reg[REG_RCD]}),
            .t_rd   (t_rd),
            .t_wr   (t_wr),
            .t_wra  (t_wra),
            .t_rp   ({8'd0, tim_reg[REG_RP]}),
            .t_rfc  ({8'd0, tim_reg[REG_RFC]}),
            .t_ras  ({8'd0, tim_reg[REG_RAS]}),
            .t_rtp  ({8'd0, tim_reg[REG_RTP]}),
            .state  (st_flat[gi]),
            .pre_ok (pre_ok_flat[gi])
         );
         assign bus.bank_state[G][A] = st_flat[gi];
      end
   endgenerate

   // Modular differences keep the checks correct across stamp wraparound.
   assign d_act    = stamp_reg - act_last_reg;
   assign d_act_bg = stamp_reg - act_bg_reg[bus.bg];
   assign d_col    = stamp_reg - col_last_reg;
   assign d_col_bg = stamp_reg - col_bg_reg[bus.bg];
   assign d_faw    = stamp_reg - faw_reg[faw_ptr_reg];

   assign rrd_bad = (act_last_vld_reg && d_act < {8'd0, tim_reg[REG_RRD_S]}) ||
                    (act_bg_vld_reg[bus.bg] && d_act_bg < {8'd0, tim_reg[REG_RRD_L]});
   assign faw_bad = faw_vld_reg[faw_ptr_reg] && d_faw < {8'd0, tim_reg[REG_FAW]};
   assign ccd_bad = (col_last_vld_reg && d_col < {8'd0, tim_reg[REG_CCD_S]}) ||
                    (col_bg_vld_reg[bus.bg] && d_col_bg < {8'd0, tim_reg[REG_CCD_L]});
   assign is_col  = (bus.cmd_op == OP_RD) || (bus.cmd_op == OP_RDA) ||
                    (bus.cmd_op == OP_WR) || (bus.cmd_op == OP_WRA);

   always_comb begin
      all_idle = 1'b1;
      prea_bad = 1'b0;
      for (int i = 0; i < NBANKS; i++) begin
         if (st_flat[i] != ST_IDLE) all_idle = 1'b0;
         if (st_flat[i] != ST_IDLE && st_flat[i] != ST_ACTIVE) prea_bad = 1'b1;
      end
   end

   always_comb begin
      code = VC_NONE;
      if (bus.cmd_valid) begin
         case (bus.cmd_op)
            OP_ACT:
               if (st_flat[sel] != ST_IDLE) code = VC_STATE;
               else if (rrd_bad)            code = VC_RRD;
               else if (faw_bad)            code = VC_FAW;
            OP_RD, OP_RDA, OP_WR, OP_WRA:
               if (st_flat[sel] != ST_ACTIVE) code = VC_STATE;
               else if (ccd_bad)              code = VC_CCD;
            OP_PRE:
               if (st_flat[sel] != ST_ACTIVE) code = VC_STATE;
               else if (!pre_ok_flat[sel])    code = VC_PRE_TIMING;
            OP_PREA:
               if (prea_bad) code = VC_STATE;
            OP_REF:
               if (!all_idle) code = VC_REF;
            default: ;
         endcase
      end
   end

   assign bus.cmd_ok    = (code == VC_NONE);
   assign accept        = bus.cmd_valid && (code == VC_NONE);
   assign bus.viol      = viol_reg;
   assign bus.viol_code = viol_code_reg;
   assign bus.ref_due   = ref_due_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG8; i++) tim_reg[i] <= default_timing(i);
         refi_reg <= DEF_REFI;
      end else if (bus.cfg_we) begin
         for (int i = 0; i < NREG8; i++)
            if (bus.cfg_addr == 4'(i)) tim_reg[i] <= bus.cfg_wdata[7:0];
         if (bus.cfg_addr == 4'(REG_REFI)) refi_reg <= bus.cfg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stamp_reg        <= '0;
         act_last_reg     <= '0;
         act_last_vld_reg <= 1'b0;
         col_last_reg     <= '0;
         col_last_vld_reg <= 1'b0;
         act_bg_vld_reg   <= '0;
         col_bg_vld_reg   <= '0;
         for (int i = 0; i < BANKGROUPS; i++) begin
            act_bg_reg[i] <= '0;
            col_bg_reg[i] <= '0;
         end
         for (int i = 0; i < 4; i++) faw_reg[i] <= '0;
         faw_vld_reg   <= '0;
         faw_ptr_reg   <= '0;
         viol_reg      <= 1'b0;
         viol_code_reg <= '0;
         refi_cnt_reg  <= '0;
         ref_due_reg   <= 1'b0;
      end else begin
         stamp_reg <= stamp_reg + 16'd1;
         viol_reg  <= bus.cmd_valid && (code != VC_NONE);
         if (bus.cmd_valid && code != VC_NONE) viol_code_reg <= code;
         if (accept && bus.cmd_op == OP_ACT) begin
            act_last_reg               <= stamp_reg;
            act_last_vld_reg           <= 1'b1;
            act_bg_reg[bus.bg]         <= stamp_reg;
            act_bg_vld_reg[bus.bg]     <= 1'b1;
            faw_reg[faw_ptr_reg]       <= stamp_reg;
            faw_vld_reg[faw_ptr_reg]   <= 1'b1;
            faw_ptr_reg                <= faw_ptr_reg + 2'd1;
         end
         if (accept && is_col) begin
            col_last_reg           <= stamp_reg;
            col_last_vld_reg       <= 1'b1;
            col_bg_reg[bus.bg]     <= stamp_reg;
            col_bg_vld_reg[bus.bg] <= 1'b1;
         end
         // An accepted REF wins over a same-cycle interval expiry.
         if (accept && bus.cmd_op == OP_REF) begin
            refi_cnt_reg <= '0;
            ref_due_reg  <= 1'b0;
         end else if (refi_cnt_reg >= refi_reg - 16'd1) begin
            refi_cnt_reg <= '0;
            ref_due_reg  <= 1'b1;
         end else begin
            refi_cnt_reg <= refi_cnt_reg + 16'd1;
         end
      end
   end
endmodule
